// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sample_fifo
//  Brief    : Tick-edge-triggered sample capture into a first-word-fall-through
//             FIFO with a separate fill-level counter and a sticky overflow
//             flag for samples dropped while full.
//  Revision : 1.0  initial release
// ============================================================================
module sample_fifo #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  tick_in,
    input  logic [WIDTH-1:0]      sample_in,
    input  logic                  out_ready,
    input  logic                  ovf_clr,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow
);

    localparam int                c_DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_FULL = (DEPTH_LOG2 + 1)'(c_DEPTH);

    // Registered state
    logic                         r_tick_q;
    logic [DEPTH_LOG2-1:0]        r_wr_ptr_q, r_wr_ptr_d;
    logic [DEPTH_LOG2-1:0]        r_rd_ptr_q, r_rd_ptr_d;
    logic [DEPTH_LOG2:0]          r_level_q,  r_level_d;
    logic                         r_ovf_q,    r_ovf_d;
    logic [WIDTH-1:0]             r_mem_q [c_DEPTH];

    // Combinational control
    logic                         w_edge;
    logic                         w_full;
    logic                         w_pop;
    logic                         w_push;
    logic                         w_drop;

    // A push needs a fresh 0->1 transition; a full FIFO still accepts the
    // push when a pop frees a slot in the same cycle.
    always_comb begin
        w_edge = tick_in & ~r_tick_q;
        w_full = (r_level_q == c_FULL);
        w_pop  = (r_level_q != '0) & out_ready;
        w_push = w_edge & (~w_full | w_pop);
        w_drop = w_edge & w_full & ~w_pop;
    end

    // Next-state for pointers, level and the sticky overflow flag
    always_comb begin
        r_wr_ptr_d = r_wr_ptr_q;
        r_rd_ptr_d = r_rd_ptr_q;
        r_level_d  = r_level_q;
        r_ovf_d    = r_ovf_q;

        if (w_push) begin
            r_wr_ptr_d = r_wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (w_pop) begin
            r_rd_ptr_d = r_rd_ptr_q + DEPTH_LOG2'(1);
        end

        case ({w_push, w_pop})
            2'b10:   r_level_d = r_level_q + (DEPTH_LOG2 + 1)'(1);
            2'b01:   r_level_d = r_level_q - (DEPTH_LOG2 + 1)'(1);
            default: r_level_d = r_level_q;
        endcase

        // A drop in the same cycle as a clear must leave the flag set
        if (w_drop) begin
            r_ovf_d = 1'b1;
        end else if (ovf_clr) begin
            r_ovf_d = 1'b0;
        end
    end

    // Control registers; tick history resets high so a level already high
    // at reset release is not mistaken for an edge
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_tick_q   <= 1'b1;
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_level_q  <= '0;
            r_ovf_q    <= 1'b0;
        end else begin
            r_tick_q   <= tick_in;
            r_wr_ptr_q <= r_wr_ptr_d;
            r_rd_ptr_q <= r_rd_ptr_d;
            r_level_q  <= r_level_d;
            r_ovf_q    <= r_ovf_d;
        end
    end

    // Sample storage, written on accepted pushes only; contents need no reset
    // because the outputs ignore them while empty
    always_ff @(posedge clk_in) begin
        if (!rst && w_push) begin
            r_mem_q[r_wr_ptr_q] <= sample_in;
        end
    end

    // Fall-through head word and status outputs
    always_comb begin
        out_data  = r_mem_q[r_rd_ptr_q];
        out_valid = (r_level_q != '0);
        level     = r_level_q;
        overflow  = r_ovf_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sample_fifo
//  Brief    : Self-checking bench for sample_fifo: directed scenarios plus
//             randomized traffic against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sample_fifo;

    localparam int c_DEPTH = 16;

    logic        clk_in;
    logic        rst;
    logic        tick_in;
    logic [15:0] sample_in;
    logic        out_ready;
    logic        ovf_clr;
    logic [15:0] out_data;
    logic        out_valid;
    logic [4:0]  level;
    logic        overflow;

    int n_total;
    int n_bad;

    // Reference model state
    logic [15:0] m_q [$];
    logic        m_prev_tick;
    logic        m_ovf;

    sample_fifo #(
        .WIDTH      (16),
        .DEPTH_LOG2 (4)
    ) u_dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .tick_in   (tick_in),
        .sample_in (sample_in),
        .out_ready (out_ready),
        .ovf_clr   (ovf_clr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .level     (level),
        .overflow  (overflow)
    );

    initial clk_in = 1'b1;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Compare every DUT output against the model's view of the FIFO
    task automatic check_model();
        chk("valid", 32'(out_valid), 32'(m_q.size() != 0));
        chk("level", 32'(level), 32'(m_q.size()));
        chk("ovf", 32'(overflow), 32'(m_ovf));
        if (m_q.size() != 0) begin
            chk("data", 32'(out_data), 32'(m_q[0]));
        end
    endtask

    // One clock: drive inputs at the falling edge, advance the model by the
    // rules of the block, then check at the next falling edge
    task automatic cycle(input logic r, input logic t, input logic [15:0] s,
                         input logic rd, input logic c);
        int  sz;
        bit  edge_seen;
        bit  pop;
        rst       = r;
        tick_in   = t;
        sample_in = s;
        out_ready = rd;
        ovf_clr   = c;
        if (r) begin
            m_q.delete();
            m_ovf       = 1'b0;
            m_prev_tick = 1'b1;
        end else begin
            sz        = m_q.size();
            edge_seen = t && !m_prev_tick;
            pop       = (sz > 0) && rd;
            if (pop) void'(m_q.pop_front());
            if (edge_seen && (sz < c_DEPTH || pop)) begin
                m_q.push_back(s);
            end else if (edge_seen) begin
                m_ovf = 1'b1;
            end else if (c) begin
                m_ovf = 1'b0;
            end
            if (edge_seen && sz >= c_DEPTH && !pop) begin
                m_ovf = 1'b1;
            end else if (c && !(edge_seen && sz >= c_DEPTH && !pop)) begin
                m_ovf = 1'b0;
            end
            m_prev_tick = t;
        end
        @(posedge clk_in);
        @(negedge clk_in);
        check_model();
    endtask

    initial begin
        n_total     = 0;
        n_bad       = 0;
        m_prev_tick = 1'b1;
        m_ovf       = 1'b0;
        rst         = 1'b1;
        tick_in     = 1'b0;
        sample_in   = '0;
        out_ready   = 1'b0;
        ovf_clr     = 1'b0;
        @(negedge clk_in);

        // Reset state
        cycle(1, 0, 16'h0, 0, 0);
        cycle(1, 0, 16'h0, 0, 0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        // Single edge push with one-cycle visibility
        cycle(0, 0, 16'h0, 0, 0);
        cycle(0, 1, 16'h1234, 0, 0);
        chk("first_valid", 32'(out_valid), 32'd1);
        chk("first_data", 32'(out_data), 32'h1234);
        chk("first_level", 32'(level), 32'd1);

        // Held tick pushes only once
        for (int i = 0; i < 10; i++) cycle(0, 1, 16'(16'hA000 + i), 0, 0);
        chk("hold_level", 32'(level), 32'd1);

        // Empty with ready: pop the one word, then ready while empty is a no-op
        cycle(0, 0, 16'h0, 1, 0);
        cycle(0, 0, 16'h0, 1, 0);
        chk("drain_level", 32'(level), 32'd0);

        // Fill to 16, then one dropped push
        for (int i = 1; i <= 16; i++) begin
            cycle(0, 0, 16'h0, 0, 0);
            cycle(0, 1, 16'(i), 0, 0);
        end
        cycle(0, 0, 16'h0, 0, 0);
        cycle(0, 1, 16'h0011, 0, 0);
        chk("full_level", 32'(level), 32'd16);
        chk("full_ovf", 32'(overflow), 32'd1);

        // Clear coinciding with a dropped push keeps the flag; clear alone drops it
        cycle(0, 0, 16'h0, 0, 0);
        cycle(0, 1, 16'h0099, 0, 1);
        chk("clr_vs_drop", 32'(overflow), 32'd1);
        cycle(0, 0, 16'h0, 0, 1);
        chk("clr_alone", 32'(overflow), 32'd0);

        // Push and pop while full: accepted, no overflow
        cycle(0, 1, 16'h0055, 1, 0);
        chk("fullpp_level", 32'(level), 32'd16);
        chk("fullpp_ovf", 32'(overflow), 32'd0);

        // Drain: 2..16 then the new word
        for (int i = 2; i <= 16; i++) begin
            chk("drain_seq", 32'(out_data), 32'(i));
            cycle(0, 0, 16'h0, 1, 0);
        end
        chk("drain_last", 32'(out_data), 32'h0055);
        cycle(0, 0, 16'h0, 1, 0);
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Reset release with tick already high: no push
        cycle(1, 1, 16'h0777, 0, 0);
        cycle(0, 1, 16'h0777, 0, 0);
        chk("rel_high", 32'(level), 32'd0);
        cycle(0, 0, 16'h0, 0, 0);
        cycle(0, 1, 16'h0888, 0, 0);
        chk("rel_edge", 32'(level), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 16'h0, 0, 0);
            cycle(0, 1, 16'(16'h0900 + i), 0, 0);
        end
        chk("pre_rst5", 32'(level), 32'd5);
        cycle(1, 0, 16'h0, 1, 1);
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0),
                  1'($urandom_range(0, 1)),
                  16'($urandom()),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 15) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sample_fifo.md
SAMPLE_FIFO -- requirements
Module: sample_fifo

Interface
REQ-001 Parameter WIDTH, default 16, sample word width in bits.
REQ-002 Parameter DEPTH_LOG2, default 4, log2 of FIFO depth (default depth 16).
REQ-003 clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 tick_in  input  1  divided sample-rate level from the upstream clock divider, synchronous to clk_in.
REQ-006 sample_in  input  WIDTH  sample word, captured on a detected tick edge.
REQ-007 out_ready  input  1  consumer accepts the head word this cycle.
REQ-008 ovf_clr  input  1  clears the sticky overflow flag.
REQ-009 out_data  output  WIDTH  head-of-FIFO word, valid only while out_valid is high.
REQ-010 out_valid  output  1  FIFO non-empty.
REQ-011 level  output  DEPTH_LOG2+1  number of stored words, 0..2^DEPTH_LOG2.
REQ-012 overflow  output  1  sticky: at least one sample dropped because the FIFO was full.

Function
REQ-013 The block SHALL register tick_in into tick_d each cycle and SHALL detect an edge when tick_in=1 and tick_d=0.
REQ-014 On a detected edge, the block SHALL push the sample_in value present in that same cycle.
REQ-015 A tick_in held high SHALL produce exactly one push; only 0->1 transitions push.
REQ-016 The FIFO SHALL be first-word-fall-through: out_data SHALL equal the oldest stored word whenever out_valid=1, with no read latency.
REQ-017 A pop SHALL occur when out_valid=1 and out_ready=1; out_ready while empty SHALL have no effect.
REQ-018 Push-to-visible latency SHALL be 1 cycle: a push in cycle N into an empty FIFO SHALL give out_valid=1 and out_data=that sample in cycle N+1.
REQ-019 Read and write pointers SHALL be DEPTH_LOG2 bits and wrap modulo 2^DEPTH_LOG2; level SHALL be a separate counter.
REQ-020 Push only: level +1. Pop only: level -1. Push and pop in the same cycle: level unchanged, both operations performed.
REQ-021 Push when full and no pop in the same cycle: the sample SHALL be dropped, pointers and level unchanged, overflow set to 1 next cycle.
REQ-022 Push when full with a simultaneous pop: the push SHALL be accepted (level stays full, no overflow).
REQ-023 Push when empty with out_ready=1 in the same cycle: no pop (out_valid was 0); level becomes 1.
REQ-024 ovf_clr=1 SHALL clear overflow next cycle; if a dropped push coincides with ovf_clr, overflow SHALL be 1 (set wins).
REQ-025 Storage content SHALL NOT affect outputs while out_valid=0; out_data is don't-care when empty.

Reset
REQ-026 While rst=1 at a clock edge: read/write pointers=0, level=0, out_valid=0, overflow=0, tick_d=1.
REQ-027 tick_d resetting to 1 SHALL suppress a push if tick_in is already high when rst deasserts; the first push requires an observed 0->1 transition.
REQ-028 rst SHALL take priority over push, pop and ovf_clr in the same cycle; a mid-operation reset discards all stored words.
REQ-029 Storage array SHALL NOT require reset.

Verification
REQ-030 Reset, then tick_in 0->1 with sample_in=0x1234, out_ready=0 -> cycle after edge: out_valid=1, out_data=0x1234, level=1.
REQ-031 Hold tick_in=1 for 10 cycles after one edge -> level stays 1; exactly one push.
REQ-032 Push 16 samples 0x0001..0x0010, out_ready=0, then one more edge with 0x0011 -> level=16, overflow=1; draining yields 0x0001..0x0010 in order, 0x0011 absent.
REQ-033 With level=16, assert edge and out_ready in the same cycle -> level stays 16, overflow stays 0, final drained word is the new sample.
REQ-034 Set overflow, then pulse ovf_clr in the same cycle as a dropped push -> overflow remains 1; pulse ovf_clr alone next -> overflow=0.
REQ-035 Release rst with tick_in=1 -> no push (level=0); after tick_in 1->0->1 -> level=1. Assert rst with level=5 -> next cycle level=0, out_valid=0.
